mdu_core: RTL and testbench
===========================

# mdu_core

Iterative RV32M multiply/divide unit sitting beside the execute stage. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation from idex, computes it over multiple cycles, and returns the destination index, busy, finish pulse and result that the commit/writeback stage consumes for deferred register writeback and hazard tracking.

## Interface
Parameters:
- DIV_BITS, 1, quotient bits retired per divide iteration. Only value 1 is supported.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- flush_from_flushunit  in  1  squashes the issue presented in the same cycle
- mdu_valid_from_idex  in  1  issue request
- mdu_op_from_idex  in  3  funct3 of the M-extension instruction
- rs1_from_idex  in  `ZCRV_XLEN  operand A
- rs2_from_idex  in  `ZCRV_XLEN  operand B
- rd_from_idex  in  `ZCRV_REG_SIZE  destination index
- mdu_now_rd_to_wb  out  `ZCRV_REG_SIZE  destination of in-flight/finished op
- mdu_busy_to_wb  out  1  operation in progress
- mdu_finish_to_wb  out  1  one-cycle result-valid pulse
- mdu_result_to_wb  out  `ZCRV_XLEN  result, valid with finish, held until next accept

## Operation
- Accept = mdu_valid_from_idex & !mdu_busy_to_wb & !flush_from_flushunit. Accept is also allowed in the finish cycle. Valid while busy is ignored; idex stalls it via stallunit.
- On accept: latch op, rd and operands. For DIV/REM, compute the operand magnitudes and the result sign.
- A flush affects only the same-cycle issue. In-flight ops are already committed and always complete.
- FSM:
  - IDLE: accept MUL* -> MUL; accept DIV* -> special-case check.
  - Divisor == 0 or signed overflow -> FIN. Otherwise -> DIV.
  - MUL (1 cycle): register the 66-bit product of 33-bit extended operands (MULH: signed×signed; MULHSU: signed×unsigned; MULHU and MUL: unsigned), then -> FIN.
  - DIV: 32 restoring iterations with counter 31..0. At count 0 -> FIN.
  - FIN: finish=1 for one cycle and result is driven. Accept here -> new state; otherwise -> IDLE.
- Result selection:
  - MUL: prod[31:0]. MULH*: prod[63:32].
  - DIV/DIVU: quotient. Negate for DIV when operand signs differ.
  - REM/REMU: remainder. Negate for REM when the dividend is negative.
- Special cases:
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend.
  - DIV overflow (0x80000000 / -1): quotient = 0x80000000; remainder = 0.
- Reset: state IDLE, busy 0, finish 0, result 0, now_rd 0, counter 0. Any in-flight op is lost.

## Timing
- The accept cycle is T.
- busy is 1 from T+1 until the last compute cycle. busy is 0 in the FIN cycle, so writeback can claim the port and issue can overlap.
- Finish cycle by op:
  - MUL*: T+2.
  - Divide special cases: T+1.
  - Normal divide: T+33 (32 iterations over T+1..T+32, FIN at T+33).
- mdu_now_rd_to_wb updates at T+1 and holds through FIN and beyond until the next accept.
- Back-to-back issue: an accept in FIN cycle F means the next op's busy asserts at F+1. No idle bubble is required.
- Reset asserted mid-operation takes priority over everything, including a FIN in the same cycle. No finish pulse follows.

## Structure
- M-extension funct3 encodings (`ZCRV_MDU_MUL … `ZCRV_MDU_REMU) go in defines.v alongside the existing `ZCRV_* widths.
- Sub-module mdu_div_core holds the restoring divider datapath: remainder/quotient shift registers, subtractor and iteration counter. It has start/done handshake and unsigned-only operands.
- mdu_core keeps the FSM, sign pre/post-processing, multiplier register and special-case detection.

## Test plan
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), rd=5 -> finish at T+2, result 0xFFFFFFEB, now_rd=5. busy high only at T+1.
- MULHU and MULHSU 0xFFFFFFFF × 0xFFFFFFFF:
  - MULHU -> 0xFFFFFFFE.
  - MULHSU -> 0xFFFFFFFF.
  - MULH -> 0x00000000.
- DIV -7 / 2 -> finish at T+33, result 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14.
- Special cases:
  - DIVU 5 / 0 -> finish at T+1, result 0xFFFFFFFF.
  - REM 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same -> 0.
- Issue with flush_from_flushunit=1 -> no accept, busy stays 0. Flush during an in-flight DIV -> op completes normally. New MUL issued in the FIN cycle -> its finish arrives 2 cycles later.
- rst_n=0 at T+10 of a DIV -> next cycle busy=0, finish=0, result=0. No finish pulse appears afterwards.

Source files
------------

// File: rtl/mdu_core_pkg.sv
// Shared widths, M-extension funct3 encodings and FSM states for the multiply/divide unit.
package mdu_core_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;

   // funct3 of the RV32M instructions
   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIN  = 2'd3
   } mdu_state_e;

   // Two's-complement negate when n is set
   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic n);
      return n ? XLEN'(-x) : x;
   endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle, start/done handshake.
module mdu_div_core
   import mdu_core_pkg::*;
#(
   parameter int unsigned DIV_BITS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done_c,
   output logic [XLEN-1:0] quotient_c,
   output logic [XLEN-1:0] remainder_c
);

   localparam int unsigned CNT_W = 5;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN / DIV_BITS - 1);

   logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;
   logic [XLEN:0]    shifted_c, diff_c;
   logic             qbit_c;
   logic [XLEN-1:0]  rem_n_c, quo_n_c;

   // One restoring step plus start/iteration control
   always_comb begin
      shifted_c = {rem_q, quo_q[XLEN-1]};
      diff_c    = shifted_c - {1'b0, dvs_q};
      qbit_c    = ~diff_c[XLEN];
      rem_n_c   = qbit_c ? diff_c[XLEN-1:0] : shifted_c[XLEN-1:0];
      quo_n_c   = {quo_q[XLEN-2:0], qbit_c};

      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (run_q) begin
         rem_d = rem_n_c;
         quo_d = quo_n_c;
         if (cnt_q == '0) run_d = 1'b0;
         else             cnt_d = cnt_q - CNT_W'(1);
      end
      if (start) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
         cnt_d = CNT_INIT;
         run_d = 1'b1;
      end
   end

   // Final step's values are exposed combinationally alongside done
   assign done_c      = run_q && (cnt_q == '0);
   assign quotient_c  = quo_n_c;
   assign remainder_c = rem_n_c;

   // Datapath and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/mdu_core.sv
// Iterative RV32M multiply/divide unit: FSM, sign handling, multiplier and divide special cases.
module mdu_core
   import mdu_core_pkg::*;
#(
   parameter int unsigned DIV_BITS = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_from_flushunit,
   input  logic             mdu_valid_from_idex,
   input  logic [2:0]       mdu_op_from_idex,
   input  logic [XLEN-1:0]  rs1_from_idex,
   input  logic [XLEN-1:0]  rs2_from_idex,
   input  logic [REG_W-1:0] rd_from_idex,
   output logic [REG_W-1:0] mdu_now_rd_to_wb,
   output logic             mdu_busy_to_wb,
   output logic             mdu_finish_to_wb,
   output logic [XLEN-1:0]  mdu_result_to_wb
);

   mdu_state_e       state_q, state_d;
   mdu_op_e          op_q, op_d, op_in_c;
   logic [XLEN-1:0]  opa_q, opa_d, opb_q, opb_d, result_q, result_d;
   logic [REG_W-1:0] now_rd_q, now_rd_d;
   logic             neg_q, neg_d, busy_q, busy_d, finish_q, finish_d;

   logic             accept_c, in_mul_c, in_signed_c, in_rem_c, dz_c, ovf_c;
   logic [XLEN-1:0]  dvd_mag_c, dvs_mag_c, spec_res_c;
   logic             div_start_c, div_done_c;
   logic [XLEN-1:0]  quo_c, rem_c, mul_res_c;
   logic [XLEN:0]    a_ext_c, b_ext_c;
   logic [2*XLEN-1:0] prod_c;

   // Issue decode, operand magnitudes and divide special-case detection
   always_comb begin
      op_in_c     = mdu_op_e'(mdu_op_from_idex);
      accept_c    = mdu_valid_from_idex & ~busy_q & ~flush_from_flushunit;
      in_mul_c    = ~mdu_op_from_idex[2];
      in_signed_c = (op_in_c == MDU_DIV) || (op_in_c == MDU_REM);
      in_rem_c    = (op_in_c == MDU_REM) || (op_in_c == MDU_REMU);
      dvd_mag_c   = cond_neg(rs1_from_idex, in_signed_c & rs1_from_idex[XLEN-1]);
      dvs_mag_c   = cond_neg(rs2_from_idex, in_signed_c & rs2_from_idex[XLEN-1]);
      dz_c        = (rs2_from_idex == '0);
      ovf_c       = in_signed_c && (rs1_from_idex == {1'b1, {(XLEN-1){1'b0}}})
                    && (rs2_from_idex == '1);
      spec_res_c  = '0;
      if (dz_c)       spec_res_c = in_rem_c ? rs1_from_idex : '1;
      else if (ovf_c) spec_res_c = in_rem_c ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // Single-cycle multiply on 33-bit extended operands; low 64 product bits suffice
   always_comb begin
      a_ext_c   = {((op_q == MDU_MULH) || (op_q == MDU_MULHSU)) & opa_q[XLEN-1], opa_q};
      b_ext_c   = {(op_q == MDU_MULH) & opb_q[XLEN-1], opb_q};
      prod_c    = (2*XLEN)'($signed(a_ext_c)) * (2*XLEN)'($signed(b_ext_c));
      mul_res_c = (op_q == MDU_MUL) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
   end

   // Next-state, latching and result selection
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      neg_d       = neg_q;
      now_rd_d    = now_rd_q;
      result_d    = result_q;
      div_start_c = 1'b0;

      case (state_q)
         ST_MUL: begin
            result_d = mul_res_c;
            state_d  = ST_FIN;
         end
         ST_DIV: begin
            if (div_done_c) begin
               result_d = cond_neg(((op_q == MDU_REM) || (op_q == MDU_REMU)) ? rem_c : quo_c,
                                   neg_q);
               state_d  = ST_FIN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept_c) begin
         op_d     = op_in_c;
         opa_d    = rs1_from_idex;
         opb_d    = rs2_from_idex;
         now_rd_d = rd_from_idex;
         neg_d    = in_signed_c & (in_rem_c ? rs1_from_idex[XLEN-1]
                                            : rs1_from_idex[XLEN-1] ^ rs2_from_idex[XLEN-1]);
         if (in_mul_c) begin
            state_d = ST_MUL;
         end else if (dz_c || ovf_c) begin
            result_d = spec_res_c;
            state_d  = ST_FIN;
         end else begin
            div_start_c = 1'b1;
            state_d     = ST_DIV;
         end
      end

      busy_d   = (state_d == ST_MUL) || (state_d == ST_DIV);
      finish_d = (state_d == ST_FIN);
   end

   mdu_div_core #(.DIV_BITS(DIV_BITS)) u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (div_start_c),
      .dividend    (dvd_mag_c),
      .divisor     (dvs_mag_c),
      .done_c      (div_done_c),
      .quotient_c  (quo_c),
      .remainder_c (rem_c)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= MDU_MUL;
         opa_q    <= '0;
         opb_q    <= '0;
         neg_q    <= 1'b0;
         now_rd_q <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         neg_q    <= neg_d;
         now_rd_q <= now_rd_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         finish_q <= finish_d;
      end
   end

   assign mdu_now_rd_to_wb = now_rd_q;
   assign mdu_busy_to_wb   = busy_q;
   assign mdu_finish_to_wb = finish_q;
   assign mdu_result_to_wb = result_q;

endmodule

// File: tb/tb_mdu_core.sv
// Directed self-checking bench for mdu_core.
module tb_mdu_core;
   import mdu_core_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             valid;
   logic [2:0]       op;
   logic [XLEN-1:0]  rs1, rs2;
   logic [REG_W-1:0] rd;
   logic [REG_W-1:0] now_rd;
   logic             busy, finish;
   logic [XLEN-1:0]  result;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mdu_core #(.DIV_BITS(1)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .flush_from_flushunit (flush),
      .mdu_valid_from_idex  (valid),
      .mdu_op_from_idex     (op),
      .rs1_from_idex        (rs1),
      .rs2_from_idex        (rs2),
      .rd_from_idex         (rd),
      .mdu_now_rd_to_wb     (now_rd),
      .mdu_busy_to_wb       (busy),
      .mdu_finish_to_wb     (finish),
      .mdu_result_to_wb     (result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present one issue before a rising edge; returns just after it (cycle T+1)
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d);
      @(negedge clk);
      valid = 1'b1; op = o; rs1 = a; rs2 = b; rd = d;
      step();
      valid = 1'b0;
   endtask

   // issue, wait for finish (bounded), check latency/result/rd/busy, then the pulse drop
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d,
                         input logic [31:0] exp_res, input int exp_lat, input logic hold_flush);
      int   lat;
      logic busy_ok;
      issue(o, a, b, d);
      if (hold_flush) flush = 1'b1;
      lat = 1;
      busy_ok = 1'b1;
      chk({tag, " rd"}, 32'(now_rd), 32'(d));
      while (!finish && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         step();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " result"}, result, exp_res);
      chk({tag, " busy pre-fin"}, 32'(busy_ok), 32'd1);
      chk({tag, " busy at fin"}, 32'(busy), 32'd0);
      flush = 1'b0;
      step();
      chk({tag, " fin pulse"}, 32'(finish), 32'd0);
      chk({tag, " result held"}, result, exp_res);
   endtask

   initial begin
      int   saw;
      rst_n = 1'b0; flush = 1'b0; valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
      repeat (3) step();
      chk("rst busy",   32'(busy),   32'd0);
      chk("rst finish", 32'(finish), 32'd0);
      chk("rst result", result,      32'd0);
      chk("rst rd",     32'(now_rd), 32'd0);
      rst_n = 1'b1;
      step();

      run_op("mul",    MDU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 2, 1'b0);
      run_op("mulhu",  MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 2, 1'b0);
      run_op("mulhsu", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 2, 1'b0);
      run_op("mulh",   MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 2, 1'b0);
      run_op("div",    MDU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd4, 32'hFFFF_FFFD, 33, 1'b0);
      run_op("rem",    MDU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 32'hFFFF_FFFF, 33, 1'b0);
      run_op("divu",   MDU_DIVU,   32'd100,       32'd7,         5'd7, 32'd14,        33, 1'b1);
      run_op("remu",   MDU_REMU,   32'd100,       32'd7,         5'd8, 32'd2,         33, 1'b0);
      run_op("divu0",  MDU_DIVU,   32'd5,         32'd0,         5'd9, 32'hFFFF_FFFF, 1, 1'b0);
      run_op("rem0",   MDU_REM,    32'd5,         32'd0,         5'd10, 32'd5,        1, 1'b0);
      run_op("divovf", MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 1'b0);
      run_op("removf", MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,        1, 1'b0);

      // flushed issue is dropped
      @(negedge clk);
      valid = 1'b1; flush = 1'b1; op = MDU_MUL; rs1 = 32'd3; rs2 = 32'd3; rd = 5'd20;
      step();
      valid = 1'b0; flush = 1'b0;
      chk("flush busy",   32'(busy),   32'd0);
      chk("flush rd",     32'(now_rd), 32'd12);
      step();
      chk("flush finish", 32'(finish), 32'd0);

      // back-to-back: new MUL accepted in the FIN cycle of a special-case divide
      issue(MDU_DIVU, 32'd5, 32'd0, 5'd13);
      chk("b2b first fin", 32'(finish), 32'd1);
      valid = 1'b1; op = MDU_MUL; rs1 = 32'd6; rs2 = 32'd7; rd = 5'd14;
      step();
      valid = 1'b0;
      chk("b2b busy F+1", 32'(busy),   32'd1);
      chk("b2b fin F+1",  32'(finish), 32'd0);
      chk("b2b rd F+1",   32'(now_rd), 32'd14);
      step();
      chk("b2b fin F+2",  32'(finish), 32'd1);
      chk("b2b result",   result,      32'd42);
      step();

      // reset in cycle T+10 of a divide
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd15);
      repeat (9) step();
      chk("rstmid busy before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rstmid busy",   32'(busy),   32'd0);
      chk("rstmid finish", 32'(finish), 32'd0);
      chk("rstmid result", result,      32'd0);
      chk("rstmid rd",     32'(now_rd), 32'd0);
      saw = 0;
      repeat (40) begin
         step();
         if (finish || busy) saw++;
      end
      chk("rstmid no fin", 32'(saw), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
